// File: rtl/systolic_sequencer.sv
// Job controller for an L-lane systolic array: operand buffers, array clear/enable sequencing,
// result capture and a valid/ready result stream. Optional RUN timeout under SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic_sequencer #(
    parameter int L = 32,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [$clog2(L)-1:0] ld_addr,
    input  logic [W-1:0]         ld_data,
    input  logic                 start,
    output logic                 start_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           run_cycles,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(L)-1:0] out_idx,
    output logic                 out_last,
    output logic                 arr_en,
    output logic                 arr_reset,
    output logic [W-1:0]         arr_a [0:L-1],
    output logic [W-1:0]         arr_b [0:L-1],
    input  logic [W-1:0]         arr_p [0:L-1],
    input  logic                 arr_ready
);
    localparam int AW = $clog2(L);
    localparam logic [AW-1:0] LAST_IDX = AW'(L - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [7:0]     cnt;
    logic [7:0]     cnt_inc;
    logic [W-1:0]   res [0:L-1];
    logic [AW-1:0]  idx;
    logic           start_acc;
    logic           last_acc;
    logic           timeout;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cnt_inc   = sat_inc(cnt);
    assign start_acc = start && (state == IDLE);
    assign last_acc  = (state == DRAIN) && out_ready && (idx == LAST_IDX);

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_CYCLES = 8'(2 * L + 8);

    assign timeout = (state == RUN) && !arr_ready && (cnt_inc == TMO_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         err <= 1'b0;
        else if (start_acc) err <= 1'b0;
        else if (timeout)   err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        arr_en      = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR:   state_nxt = RUN;
            RUN: begin
                arr_en = 1'b1;
                if (arr_ready)    state_nxt = CAPTURE;
                else if (timeout) state_nxt = IDLE;
            end
            CAPTURE: state_nxt = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                if (last_acc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done     = last_acc;
    assign out_data = res[idx];
    assign out_idx  = idx;
    assign out_last = (idx == LAST_IDX);

    // arr_reset is registered so it stays high through reset and falls on the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) arr_reset <= 1'b1;
        else        arr_reset <= (state_nxt == CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 8'd0;
            run_cycles <= 8'd0;
            idx        <= '0;
        end else begin
            case (state)
                CLEAR:   cnt <= 8'd0;
                RUN: begin
                    cnt <= cnt_inc;
                    if (arr_ready) run_cycles <= cnt_inc;
                end
                CAPTURE: idx <= '0;
                DRAIN:   if (out_ready) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) begin
                arr_a[i] <= '0;
                arr_b[i] <= '0;
            end
        end else if ((state == IDLE) && ld_en) begin
            if (ld_sel) arr_b[ld_addr] <= ld_data;
            else        arr_a[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < L; i++) res[i] <= '0;
        end else if (state == CAPTURE) begin
            for (int i = 0; i < L; i++) res[i] <= arr_p[i];
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer (L=4) with a stub array that raises ready on its 11th enabled cycle.
module tb_systolic_sequencer;
    localparam int L = 4;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_en = 1'b0;
    logic        ld_sel = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        start_ready, busy, done, err, out_valid, out_last, arr_en, arr_reset;
    logic [7:0]  run_cycles;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic [15:0] arr_a [0:L-1];
    logic [15:0] arr_b [0:L-1];
    logic [15:0] arr_p [0:L-1];
    logic        arr_ready;
    logic        stub_hang = 1'b0;
    logic [7:0]  en_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    systolic_sequencer #(.L(L), .W(W)) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .start_ready(start_ready), .busy(busy), .done(done), .err(err),
        .run_cycles(run_cycles),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .arr_en(arr_en), .arr_reset(arr_reset), .arr_a(arr_a), .arr_b(arr_b),
        .arr_p(arr_p), .arr_ready(arr_ready)
    );

    always #5 clk = ~clk;

    // Stub array: counts enabled cycles since its last clear, ready on the 11th, P[i] = 3i+1
    always @(posedge clk) begin
        if (arr_reset)   en_cnt <= 8'd0;
        else if (arr_en) en_cnt <= en_cnt + 8'd1;
    end
    assign arr_ready = arr_en && !stub_hang && (en_cnt == 8'd10);
    always_comb begin
        for (int i = 0; i < L; i++) arr_p[i] = 16'(3 * i + 1);
    end

    always @(posedge clk) begin
        if (reset && done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int n;
        int exp_j;
        logic [3:0] pat;

        // Reset held for 3 cycles
        repeat (3) tick();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_arr_en", arr_en, 0);
        chk("rst_arr_reset", arr_reset, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_arr_a0", arr_a[0], 0);
        reset = 1'b1;
        #1;
        chk("rel_arr_reset_hold", arr_reset, 1);
        tick();
        chk("rel_arr_reset_fall", arr_reset, 0);

        // Load a={1,2,3,4}, b={5,6,7,8}; last b write shares its cycle with start
        for (int i = 0; i < L; i++) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'(i); ld_data = 16'(i + 1);
            tick();
        end
        for (int i = 0; i < L - 1; i++) begin
            ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 2'(i); ld_data = 16'(i + 5);
            tick();
        end
        ld_addr = 2'd3; ld_data = 16'd8; start = 1'b1;
        tick();
        ld_en = 1'b0; start = 1'b0;
        #1;
        chk("clear_arr_reset", arr_reset, 1);
        chk("clear_arr_en", arr_en, 0);
        chk("clear_busy", busy, 1);
        chk("clear_start_ready", start_ready, 0);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("arr_a%0d", i), arr_a[i], 32'(i + 1));
            chk($sformatf("arr_b%0d", i), arr_b[i], 32'(i + 5));
        end
        tick();
        n = 1;
        chk("run1_arr_en", arr_en, 1);
        chk("run1_arr_reset", arr_reset, 0);
        // start and a write during RUN must both be ignored
        start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd0; ld_data = 16'hFFFF;
        tick();
        n = 2;
        start = 1'b0; ld_en = 1'b0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("job1_latency_from_clear", n, 13);
        out_ready = 1'b1;
        for (int j = 0; j < L; j++) begin
            if (j == 1) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 2'd0; ld_data = 16'hFFFF;
            end
            #1;
            chk("job1_valid", out_valid, 1);
            chk("job1_data", out_data, 32'(3 * j + 1));
            chk("job1_idx", out_idx, 32'(j));
            chk("job1_last", out_last, (j == L - 1) ? 1 : 0);
            chk("job1_done", done, (j == L - 1) ? 1 : 0);
            tick();
            start = 1'b0; ld_en = 1'b0;
        end
        #1;
        chk("job1_idle_ready", start_ready, 1);
        chk("job1_idle_valid", out_valid, 0);
        chk("job1_done_low", done, 0);
        chk("job1_run_cycles", run_cycles, 11);
        chk("job1_buf_kept", arr_a[0], 1);
        chk("job1_done_count", done_cnt, 1);
        tick(); tick();
        chk("job1_no_second_job", busy, 0);

        // Re-run without reload, out_ready pattern 1,0,0,1 repeating
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("job2_latency_from_clear", n, 13);
        pat = 4'b1001;
        exp_j = 0;
        for (int cyc = 0; cyc < 40 && exp_j < L; cyc++) begin
            out_ready = pat[cyc % 4];
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 32'(3 * exp_j + 1));
            chk("bp_idx", out_idx, 32'(exp_j));
            chk("bp_last", out_last, (exp_j == L - 1) ? 1 : 0);
            chk("bp_done", done, (out_ready && exp_j == L - 1) ? 1 : 0);
            if (out_ready) exp_j++;
            tick();
        end
        chk("bp_words", exp_j, 4);
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_done_count", done_cnt, 2);
        out_ready = 1'b1;

        // Reset during RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("rr_in_run", arr_en, 1);
        reset = 1'b0;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_start_ready", start_ready, 1);
        chk("rr_arr_en", arr_en, 0);
        chk("rr_arr_reset", arr_reset, 1);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_buf_a0", arr_a[0], 0);
        chk("rr_buf_b3", arr_b[3], 0);
        chk("rr_run_cycles", run_cycles, 0);
        tick();
        reset = 1'b1;
        tick();

        // Reset during DRAIN
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("rd_reached_drain", out_valid, 1);
        tick();
        chk("rd_second_word", out_idx, 1);
        reset = 1'b0;
        #1;
        chk("rd_out_valid", out_valid, 0);
        chk("rd_busy", busy, 0);
        chk("rd_done", done, 0);
        chk("rd_buf_a1", arr_a[1], 0);
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("rd_done_count", done_cnt, 2);

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
        // Stub never raises ready: timeout after 2L+8 = 16 RUN cycles
        stub_hang = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        exp_j = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (out_valid) exp_j++;
        end
        chk("to_cycles_from_clear", n, 17);
        chk("to_err", err, 1);
        chk("to_arr_en", arr_en, 0);
        chk("to_no_valid", exp_j, 0);
        chk("to_done_count", done_cnt, 2);
        stub_hang = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("to_err_cleared", err, 0);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
